// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU sequencer: command codes, ALU op codes,
// FSM states and the decoded control bundle.
package alu_seq_pkg;

    localparam logic [2:0] CMD_AND = 3'd0;
    localparam logic [2:0] CMD_OR  = 3'd1;
    localparam logic [2:0] CMD_ADD = 3'd2;
    localparam logic [2:0] CMD_SUB = 3'd3;
    localparam logic [2:0] CMD_SLT = 3'd4;
    localparam logic [2:0] CMD_NOR = 3'd5;
    localparam logic [2:0] CMD_MUL = 3'd6;

    localparam logic [2:0] ALUOP_AND = 3'b000;
    localparam logic [2:0] ALUOP_OR  = 3'b001;
    localparam logic [2:0] ALUOP_ADD = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    typedef struct packed {
        logic [2:0] op;
        logic       ainvert;
        logic       bnegate;
        logic       cin;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/alu_seq_decode.sv
// Command to ALU slice control decode. MUL is legal only when the
// ALU_SEQ_MUL_EN macro is defined.
module alu_seq_decode
    import alu_seq_pkg::*;
(
    input  logic [2:0] i_cmd,
    output dec_t       o_dec
);

    always_comb begin
        o_dec = '0;
        case (i_cmd)
            CMD_AND: o_dec.op = ALUOP_AND;
            CMD_OR:  o_dec.op = ALUOP_OR;
            CMD_ADD: o_dec.op = ALUOP_ADD;
            CMD_SUB, CMD_SLT: begin
                o_dec.op      = ALUOP_ADD;
                o_dec.bnegate = 1'b1;
                o_dec.cin     = 1'b1;
            end
            // De Morgan: ~a & ~b
            CMD_NOR: begin
                o_dec.op      = ALUOP_AND;
                o_dec.ainvert = 1'b1;
                o_dec.bnegate = 1'b1;
            end
`ifdef ALU_SEQ_MUL_EN
            CMD_MUL: o_dec.op = ALUOP_ADD;
`endif
            default: o_dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_seq_driver.sv
// Valid/ready sequencer driving an external combinational ALU; optional
// shift-add multiply compiled in with ALU_SEQ_MUL_EN.
module alu_seq_driver
    import alu_seq_pkg::*;
#(
    parameter int W         = 16,
    parameter int MUL_ITERS = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [2:0]   req_cmd,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [W-1:0] resp_result,
    output logic         resp_zero,
    output logic         resp_ovf,
    output logic         resp_cout,
    output logic         resp_illegal,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic         alu_cin,
    output logic         alu_ainvert,
    output logic         alu_bnegate,
    output logic [2:0]   alu_op,
    input  logic [W-1:0] alu_result,
    input  logic         alu_cout
);

    if (MUL_ITERS != W) begin : g_iters_chk
        $error("alu_seq_driver: MUL_ITERS must equal W");
    end

    state_t         r_state, w_next;
    dec_t           w_dec;
    logic           w_accept;
    logic [2:0]     r_cmd;
    logic [W-1:0]   r_alu_a, r_alu_b;
    logic [2:0]     r_alu_op;
    logic           r_alu_cin, r_alu_ainvert, r_alu_bnegate;
    logic [W-1:0]   r_resp_result;
    logic           r_resp_zero, r_resp_ovf, r_resp_cout, r_resp_illegal;
    logic           w_add_ovf, w_sub_ovf;
    logic [W-1:0]   w_exec_res;
    logic           w_exec_ovf;

`ifdef ALU_SEQ_MUL_EN
    localparam int CNT_W = $clog2(MUL_ITERS + 1);
    logic [W-1:0]     r_mplier;
    logic [CNT_W-1:0] r_cnt;
`endif

    alu_seq_decode u_decode (
        .i_cmd (req_cmd),
        .o_dec (w_dec)
    );

    assign w_accept = req_valid && (r_state == ST_IDLE);

    // r_alu_b holds the un-negated B, so overflow is judged on the raw operands.
    assign w_add_ovf = (r_alu_a[W-1] == r_alu_b[W-1]) && (alu_result[W-1] != r_alu_a[W-1]);
    assign w_sub_ovf = (r_alu_a[W-1] != r_alu_b[W-1]) && (alu_result[W-1] != r_alu_a[W-1]);

    always_comb begin
        w_exec_res = alu_result;
        w_exec_ovf = 1'b0;
        case (r_cmd)
            CMD_ADD: w_exec_ovf = w_add_ovf;
            CMD_SUB: w_exec_ovf = w_sub_ovf;
            CMD_SLT: begin
                w_exec_res = {{(W-1){1'b0}}, alu_result[W-1] ^ w_sub_ovf};
                w_exec_ovf = w_sub_ovf;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) begin
                if (w_dec.illegal)
                    w_next = ST_RESP;
`ifdef ALU_SEQ_MUL_EN
                else if (req_cmd == CMD_MUL)
                    w_next = ST_MUL;
`endif
                else
                    w_next = ST_EXEC;
            end
            ST_EXEC: w_next = ST_RESP;
`ifdef ALU_SEQ_MUL_EN
            ST_MUL:  if (r_cnt == '0) w_next = ST_RESP;
`endif
            ST_RESP: if (resp_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd          <= '0;
            r_alu_a        <= '0;
            r_alu_b        <= '0;
            r_alu_op       <= '0;
            r_alu_cin      <= 1'b0;
            r_alu_ainvert  <= 1'b0;
            r_alu_bnegate  <= 1'b0;
            r_resp_result  <= '0;
            r_resp_zero    <= 1'b0;
            r_resp_ovf     <= 1'b0;
            r_resp_cout    <= 1'b0;
            r_resp_illegal <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            r_mplier       <= '0;
            r_cnt          <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept) begin
                    r_cmd         <= req_cmd;
                    r_alu_a       <= req_a;
                    r_alu_b       <= req_b;
                    r_alu_op      <= w_dec.op;
                    r_alu_cin     <= w_dec.cin;
                    r_alu_ainvert <= w_dec.ainvert;
                    r_alu_bnegate <= w_dec.bnegate;
                    r_resp_cout   <= 1'b0;
                    if (w_dec.illegal) begin
                        r_resp_result  <= '0;
                        r_resp_zero    <= 1'b1;
                        r_resp_ovf     <= 1'b0;
                        r_resp_illegal <= 1'b1;
                    end
`ifdef ALU_SEQ_MUL_EN
                    // alu_a doubles as the accumulator, alu_b as the multiplicand.
                    if (!w_dec.illegal && req_cmd == CMD_MUL) begin
                        r_alu_a  <= '0;
                        r_alu_b  <= req_a;
                        r_mplier <= req_b;
                        r_cnt    <= CNT_W'(MUL_ITERS);
                    end
`endif
                end
                ST_EXEC: begin
                    r_resp_result  <= w_exec_res;
                    r_resp_zero    <= (w_exec_res == '0);
                    r_resp_ovf     <= w_exec_ovf;
                    r_resp_cout    <= alu_cout;
                    r_resp_illegal <= 1'b0;
                end
`ifdef ALU_SEQ_MUL_EN
                ST_MUL: begin
                    if (r_cnt != '0) begin
                        if (r_mplier[0]) begin
                            r_alu_a     <= alu_result;
                            r_resp_cout <= r_resp_cout | alu_cout;
                        end
                        r_alu_b  <= r_alu_b << 1;
                        r_mplier <= r_mplier >> 1;
                        r_cnt    <= r_cnt - 1'b1;
                    end else begin
                        r_resp_result  <= r_alu_a;
                        r_resp_zero    <= (r_alu_a == '0);
                        r_resp_ovf     <= 1'b0;
                        r_resp_illegal <= 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign req_ready    = (r_state == ST_IDLE);
    assign resp_valid   = (r_state == ST_RESP);
    assign resp_result  = r_resp_result;
    assign resp_zero    = r_resp_zero;
    assign resp_ovf     = r_resp_ovf;
    assign resp_cout    = r_resp_cout;
    assign resp_illegal = r_resp_illegal;
    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign alu_cin      = r_alu_cin;
    assign alu_ainvert  = r_alu_ainvert;
    assign alu_bnegate  = r_alu_bnegate;
    assign alu_op       = r_alu_op;

endmodule

// File: tb/tb_alu_seq_driver.sv
// Directed bench for alu_seq_driver with a behavioural ALU slice model.
module tb_alu_seq_driver;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [2:0]   req_cmd = '0;
    logic [W-1:0] req_a = '0, req_b = '0;
    logic         resp_valid;
    logic         resp_ready = 1'b0;
    logic [W-1:0] resp_result;
    logic         resp_zero, resp_ovf, resp_cout, resp_illegal;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic         alu_cin, alu_ainvert, alu_bnegate, alu_cout;
    logic [2:0]   alu_op;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_seq_driver #(.W(W), .MUL_ITERS(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
        .resp_zero(resp_zero), .resp_ovf(resp_ovf), .resp_cout(resp_cout),
        .resp_illegal(resp_illegal),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_ainvert(alu_ainvert),
        .alu_bnegate(alu_bnegate), .alu_op(alu_op),
        .alu_result(alu_result), .alu_cout(alu_cout)
    );

    // ALU slice model: ripple adder carry is always produced.
    logic [W-1:0] m_a, m_b;
    logic [W:0]   m_sum;
    always_comb begin
        m_a   = alu_ainvert ? ~alu_a : alu_a;
        m_b   = alu_bnegate ? ~alu_b : alu_b;
        m_sum = {1'b0, m_a} + {1'b0, m_b} + {{W{1'b0}}, alu_cin};
        alu_cout = m_sum[W];
        case (alu_op)
            3'b000:  alu_result = m_a & m_b;
            3'b001:  alu_result = m_a | m_b;
            default: alu_result = m_sum[W-1:0];
        endcase
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Presents one request and waits for resp_valid; lat counts edges from accept.
    task automatic issue(input logic [2:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat);
        @(negedge clk);
        req_cmd = cmd; req_a = a; req_b = b; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic ack();
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    typedef struct {
        logic [2:0]   cmd;
        logic [W-1:0] a, b, res;
        logic         z, o, c, il;
        int           lat;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int  lat;
        bit  seen;
        logic [W-1:0] held;

        vecs[0]  = '{3'd0, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 1'b1, 1'b0, 2};
        vecs[1]  = '{3'd1, 16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 2};
        vecs[2]  = '{3'd2, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 2};
        vecs[3]  = '{3'd2, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 2};
        vecs[4]  = '{3'd3, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 2};
        vecs[5]  = '{3'd3, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b1, 1'b0, 2};
        vecs[6]  = '{3'd4, 16'h8000, 16'h0001, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b0, 2};
        vecs[7]  = '{3'd4, 16'h7FFF, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 2};
        vecs[8]  = '{3'd4, 16'h0003, 16'h0007, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 2};
        vecs[9]  = '{3'd5, 16'h00F0, 16'h0F00, 16'hF00F, 1'b0, 1'b0, 1'b1, 1'b0, 2};
        vecs[10] = '{3'd7, 16'h0001, 16'h0002, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1};
`ifdef ALU_SEQ_MUL_EN
        vecs[11] = '{3'd6, 16'd300, 16'd200, 16'hEA60, 1'b0, 1'b0, 1'b0, 1'b0, 18};
`else
        vecs[11] = '{3'd6, 16'd300, 16'd200, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1};
`endif

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_resp_result", resp_result, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_req_ready", req_ready, 1);

        foreach (vecs[i]) begin
            issue(vecs[i].cmd, vecs[i].a, vecs[i].b, lat);
            check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
            check($sformatf("v%0d_result", i), resp_result, vecs[i].res);
            check($sformatf("v%0d_zero", i), resp_zero, vecs[i].z);
            check($sformatf("v%0d_ovf", i), resp_ovf, vecs[i].o);
            check($sformatf("v%0d_cout", i), resp_cout, vecs[i].c);
            check($sformatf("v%0d_illegal", i), resp_illegal, vecs[i].il);
            ack();
            check($sformatf("v%0d_back_idle", i), {req_ready, resp_valid}, 2'b10);
        end

        // SUB controls reach the ALU on the accept edge
        @(negedge clk);
        req_cmd = 3'd3; req_a = 16'h0009; req_b = 16'h0004; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("sub_ctl", {alu_op, alu_ainvert, alu_bnegate, alu_cin}, {3'b010, 1'b0, 1'b1, 1'b1});
        check("sub_ops", {alu_a, alu_b}, {16'h0009, 16'h0004});
        @(posedge clk); #1;
        check("sub_result", resp_result, 16'h0005);
        ack();

        // Backpressure: response held stable
        issue(3'd2, 16'h1111, 16'h2222, lat);
        held = resp_result;
        check("bp_result", held, 16'h3333);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d", k), {resp_valid, req_ready, resp_result},
                  {1'b1, 1'b0, 16'h3333});
        end
        ack();
        check("bp_release", {req_ready, resp_valid}, 2'b10);

        // Reset in the middle of a command
        @(negedge clk);
        req_cmd = 3'd6; req_a = 16'd300; req_b = 16'd200; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_outs", {resp_valid, alu_a, alu_b, alu_op, alu_cin, alu_bnegate,
                               resp_result, resp_illegal, resp_zero}, '0);
        check("mid_rst_ready", req_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        check("mid_rst_no_resp", seen, 0);
        issue(3'd2, 16'h0002, 16'h0003, lat);
        check("after_rst_add", resp_result, 16'h0005);
        check("after_rst_lat", lat, 2);
        ack();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
